// File: rtl/adder_tb_pkg.sv
// rtl/adder_tb_pkg.sv - shared types and constants for the adder stream driver
package adder_tb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [3:0]  REFRESH_ALL = 4'hF;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/expect_fifo.sv
// rtl/expect_fifo.sv - synchronous FIFO of expected sums with clear and occupancy count
module expect_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/adder_stream_driver.sv
// rtl/adder_stream_driver.sv - issues operand triples to the pipelined adder and scoreboards its sums
module adder_stream_driver
  import adder_tb_pkg::*;
#(
  parameter int          WIDTH = WIDTH_DEF,
  parameter int          DEPTH = 8,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_ops,
  input  logic [7:0]       stall_mask,
  input  logic             flush_req,
  output logic             valid_out,
  input  logic             pipe_in_allow,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic             c_in,
  input  logic             pipe_valid,
  input  logic [WIDTH-1:0] pipe_sum,
  input  logic             pipe_cout,
  output logic             out_allow,
  output logic [3:0]       pipe_flush,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           state, state_nx;
  logic [15:0]      issue_left;
  logic [WIDTH-1:0] a_ctr;
  logic [31:0]      lfsr;
  logic [WIDTH-1:0] lfsr_w;
  logic [7:0]       mask;
  logic [2:0]       ptr;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   head;
  logic [WIDTH:0]   exp_sum;
  logic             start_ok, issue_hs, res_hs, pop, res_bad, fifo_clear;

  always_comb begin
    state_nx   = state;
    valid_out  = 1'b0;
    out_allow  = 1'b0;
    pipe_flush = '0;
    start_ok   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_nx = (num_ops == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        valid_out = (issue_left != '0) && (count < FULL);
        out_allow = mask[ptr];
        if (flush_req)               state_nx = FLUSH;
        else if (issue_left == '0)   state_nx = DRAIN;
      end
      DRAIN: begin
        out_allow = mask[ptr];
        if (flush_req)               state_nx = FLUSH;
        else if (count == '0)        state_nx = DONE;
      end
      FLUSH: begin
        pipe_flush = REFRESH_ALL;
        state_nx   = (issue_left != '0) ? RUN : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign lfsr_w     = WIDTH'(lfsr);
  assign data_a     = valid_out ? a_ctr  : '0;
  assign data_b     = valid_out ? lfsr_w : '0;
  assign c_in       = valid_out & lfsr[0];
  assign busy       = (state == RUN) || (state == DRAIN) || (state == FLUSH);
  assign done       = (state == DONE);

  assign issue_hs   = valid_out & pipe_in_allow;
  assign res_hs     = out_allow & pipe_valid;
  assign pop        = res_hs & (count != '0);
  // a result with nothing outstanding is as wrong as a bad sum
  assign res_bad    = res_hs && ((count == '0) || ({pipe_cout, pipe_sum} != head));
  assign exp_sum    = {1'b0, a_ctr} + {1'b0, lfsr_w} + {{WIDTH{1'b0}}, lfsr[0]};
  assign fifo_clear = (state == FLUSH) | start_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      issue_left <= '0;
      a_ctr      <= '0;
      lfsr       <= SEED;
      mask       <= '0;
      ptr        <= '0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
      mismatch   <= 1'b0;
    end else begin
      state    <= state_nx;
      mismatch <= res_bad;
      if (start_ok) begin
        issue_left <= num_ops;
        mask       <= stall_mask;
        ptr        <= '0;
        pass_cnt   <= '0;
        err_cnt    <= '0;
        drop_cnt   <= '0;
      end
      if ((state == RUN) || (state == DRAIN)) ptr <= ptr + 3'd1;
      if (issue_hs) begin
        a_ctr      <= a_ctr + 1'b1;
        lfsr       <= lfsr_next(lfsr);
        issue_left <= issue_left - 16'd1;
      end
      if (res_hs) begin
        if (res_bad) err_cnt  <= sat_add16(err_cnt, 16'd1);
        else         pass_cnt <= sat_add16(pass_cnt, 16'd1);
      end
      if (state == FLUSH) drop_cnt <= sat_add16(drop_cnt, 16'(count));
    end
  end

  expect_fifo #(.DEPTH(DEPTH), .DW(WIDTH + 1)) u_expect_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (issue_hs),
    .push_data (exp_sum),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

endmodule

// File: tb/tb_adder_stream_driver.sv
// tb/tb_adder_stream_driver.sv - randomized self-checking bench with behavioural model and ideal adder
module tb_adder_stream_driver;

  localparam int D    = 8;
  localparam int LAT  = 2;
  localparam int ACAP = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FLUSH = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, flush_req, pipe_in_allow, pipe_valid, pipe_cout;
  logic [15:0] num_ops;
  logic [7:0]  stall_mask;
  logic [31:0] pipe_sum;
  logic        valid_out, c_in, out_allow, busy, done, mismatch;
  logic [31:0] data_a, data_b;
  logic [3:0]  pipe_flush;
  logic [15:0] pass_cnt, err_cnt, drop_cnt;

  always #5 clk = ~clk;

  adder_stream_driver dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .stall_mask(stall_mask),
    .flush_req(flush_req), .valid_out(valid_out), .pipe_in_allow(pipe_in_allow),
    .data_a(data_a), .data_b(data_b), .c_in(c_in), .pipe_valid(pipe_valid),
    .pipe_sum(pipe_sum), .pipe_cout(pipe_cout), .out_allow(out_allow),
    .pipe_flush(pipe_flush), .busy(busy), .done(done), .mismatch(mismatch),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model of the driver
  int          m_mode, m_left, m_ptr, m_pass, m_err, m_drop, m_max;
  logic [31:0] m_a, m_lfsr;
  logic [7:0]  m_mask;
  logic [32:0] m_q[$];
  bit          m_mm, m_first_seen;
  logic [32:0] m_first;

  // ideal adder: fixed latency, bounded occupancy, drops everything on refresh
  logic [32:0] a_sum[$];
  int          a_age[$];
  bit          hold_in = 0, hold_out = 0, rand_stall = 0;
  int          flip_at = -1;
  int          res_idx = 0;
  int          mm_pulses = 0;

  function automatic logic [31:0] step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_ptr = 0; m_pass = 0; m_err = 0; m_drop = 0;
    m_a = '0; m_lfsr = 32'h1; m_mask = '0; m_mm = 0; m_q.delete();
    a_sum.delete(); a_age.delete(); res_idx = 0;
  endtask

  always @(negedge clk) begin
    logic [32:0] got, ex;
    bit e_valid, e_oa, iss, res;
    int old_left, old_size;
    if (!rst) model_reset();
    pipe_valid = !hold_out && (a_sum.size() > 0) && (a_age[0] >= LAT);
    got = (a_sum.size() > 0) ? a_sum[0] : '0;
    if (res_idx == flip_at) got[0] = ~got[0];
    {pipe_cout, pipe_sum} = got;
    pipe_in_allow = !hold_in && (a_sum.size() < ACAP) && (!rand_stall || $urandom_range(3) != 0);
    #1;
    e_valid = (m_mode == M_RUN) && (m_left > 0) && (m_q.size() < D);
    e_oa    = ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && m_mask[m_ptr];
    check("cycle",
      {valid_out, out_allow, pipe_flush, busy, done, mismatch, c_in, data_a, data_b,
       pass_cnt, err_cnt, drop_cnt},
      {e_valid, e_oa, (m_mode == M_FLUSH) ? 4'hF : 4'h0,
       (m_mode == M_RUN) || (m_mode == M_DRAIN) || (m_mode == M_FLUSH), m_mode == M_DONE, m_mm,
       e_valid & m_lfsr[0], e_valid ? m_a : 32'h0, e_valid ? m_lfsr : 32'h0,
       16'(m_pass), 16'(m_err), 16'(m_drop)});
    if (mismatch) mm_pulses++;
    if (rst) begin
      old_left = m_left;
      old_size = m_q.size();
      iss = e_valid && pipe_in_allow;
      res = e_oa && pipe_valid;
      m_mm = 0;
      if (res) begin
        res_idx++;
        if (old_size > 0) begin
          ex = m_q.pop_front();
          if (ex == {pipe_cout, pipe_sum}) m_pass = sat(m_pass + 1);
          else begin m_err = sat(m_err + 1); m_mm = 1; end
        end else begin
          m_err = sat(m_err + 1); m_mm = 1;
        end
      end
      if (iss) begin
        ex = {1'b0, m_a} + {1'b0, m_lfsr} + 33'(m_lfsr[0]);
        if (!m_first_seen) begin m_first = ex; m_first_seen = 1; end
        m_q.push_back(ex);
        m_a = m_a + 1; m_lfsr = step(m_lfsr); m_left--;
      end
      if (m_q.size() > m_max) m_max = m_q.size();
      if ((m_mode == M_RUN) || (m_mode == M_DRAIN)) m_ptr = (m_ptr + 1) % 8;
      case (m_mode)
        M_IDLE, M_DONE: if (start) begin
          m_left = num_ops; m_mask = stall_mask; m_ptr = 0;
          m_pass = 0; m_err = 0; m_drop = 0; m_q.delete();
          m_first_seen = 0; res_idx = 0;
          m_mode = (num_ops == 0) ? M_DONE : M_RUN;
        end
        M_RUN:   if (flush_req) m_mode = M_FLUSH; else if (old_left == 0) m_mode = M_DRAIN;
        M_DRAIN: if (flush_req) m_mode = M_FLUSH; else if (old_size == 0) m_mode = M_DONE;
        M_FLUSH: begin
          m_drop = sat(m_drop + old_size); m_q.delete();
          m_mode = (m_left > 0) ? M_RUN : M_DONE;
        end
        default: m_mode = M_IDLE;
      endcase
      if (pipe_flush != 4'h0) begin
        a_sum.delete(); a_age.delete();
      end else begin
        if (pipe_valid && out_allow) begin void'(a_sum.pop_front()); void'(a_age.pop_front()); end
        foreach (a_age[i]) a_age[i]++;
        if (valid_out && pipe_in_allow) begin
          a_sum.push_back({1'b0, data_a} + {1'b0, data_b} + 33'(c_in));
          a_age.push_back(0);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic go(input int ops, input logic [7:0] msk);
    num_ops = 16'(ops); stall_mask = msk; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin cyc(1); n++; end
    check({name, " done"}, done, 1);
  endtask

  task automatic check_cnts(input string name, input int p, input int e, input int d);
    check({name, " counters"}, {pass_cnt, err_cnt, drop_cnt}, {16'(p), 16'(e), 16'(d)});
  endtask

  initial begin
    int n;
    start = 0; flush_req = 0; num_ops = '0; stall_mask = '0;
    pipe_in_allow = 0; pipe_valid = 0; pipe_sum = '0; pipe_cout = 0;
    #1 rst = 1'b0;
    cyc(3);
    check("reset outputs", {busy, done, valid_out, out_allow, pipe_flush, mismatch, data_a, data_b,
                            pass_cnt, err_cnt, drop_cnt}, '0);
    check("lfsr step", step(32'h1), 32'h8020_0003);
    rst = 1'b1;
    cyc(1);

    go(4, 8'hFF);
    wait_done("basic", 500);
    check("first expect", m_first, 33'h2);
    check_cnts("basic", 4, 0, 0);

    hold_in = 1;
    go(5, 8'hFF);
    cyc(3);
    check("held operands", {valid_out, c_in, data_a, data_b}, {1'b1, 1'b1, 32'h4, 32'hB02C_0003});
    hold_in = 0;
    wait_done("in stall", 500);
    check_cnts("in stall", 5, 0, 0);

    m_max = 0;
    go(20, 8'h55);
    wait_done("half rate", 1000);
    check("fifo peak", m_max, D);
    check_cnts("half rate", 20, 0, 0);

    flip_at = 2; mm_pulses = 0;
    go(6, 8'hFF);
    wait_done("bad sum", 500);
    flip_at = -1;
    check_cnts("bad sum", 5, 1, 0);
    check("mismatch pulses", mm_pulses, 1);

    hold_out = 1;
    go(10, 8'hFF);
    n = 0;
    while (m_q.size() != 3 && n < 50) begin cyc(1); n++; end
    check("three outstanding", m_q.size(), 3);
    hold_in = 1; flush_req = 1;
    cyc(1);
    flush_req = 0;
    check("flush pulse", {pipe_flush, busy, valid_out, out_allow}, {4'hF, 1'b1, 1'b0, 1'b0});
    cyc(1);
    check("after flush", {pipe_flush, drop_cnt}, {4'h0, 16'd3});
    hold_in = 0; hold_out = 0;
    wait_done("flush", 500);
    check_cnts("flush", 7, 0, 3);

    go(0, 8'hFF);
    check("zero ops", {busy, done}, 2'b01);

    for (int r = 0; r < 8; r++) begin
      rand_stall = 1;
      go($urandom_range(1, 40), 8'($urandom_range(255)) | 8'h01);
      if ($urandom_range(1) == 1) begin
        cyc($urandom_range(1, 12));
        flush_req = 1;
        cyc(1);
        flush_req = 0;
      end
      wait_done("random", 3000);
    end
    rand_stall = 0;

    go(30, 8'hA5);
    cyc(8);
    rst = 1'b0;
    #1;
    check("async reset", {busy, done, valid_out, out_allow, pipe_flush, mismatch, data_a, data_b,
                          pass_cnt, err_cnt, drop_cnt}, '0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    go(5, 8'hFF);
    wait_done("post reset", 500);
    check("post reset first", m_first, 33'h2);
    check_cnts("post reset", 5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
